// File: rtl/sfifo_wr_arbiter.sv
// rtl/sfifo_wr_arbiter.sv - round-robin burst arbiter sharing one sfifo write port
module sfifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_write,
    output logic [DATA_W-1:0]           fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]   winner;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic              found;
    logic              owner_valid;
    logic              accept;
    int                idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        found        = 1'b0;
        winner       = '0;
        idx          = 0;
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        req_ready    = '0;
        fifo_write   = 1'b0;
        fifo_wdata   = '0;

        // Cyclic scan starting at rr_ptr; first valid producer wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end

        owner_valid = req_valid[owner];
        accept      = (state == HOLD) && owner_valid && !fifo_full;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = HOLD;
                    owner_nxt    = winner;
                    beat_cnt_nxt = '0;
                end
            end
            HOLD: begin
                // A dropped valid ends the burst even while the FIFO is full.
                if (!owner_valid || (accept && beat_cnt == LAST_BEAT)) begin
                    state_nxt    = IDLE;
                    rr_ptr_nxt   = (owner == LAST_ID) ? '0 : owner + ID_W'(1);
                    beat_cnt_nxt = '0;
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!rst && state == HOLD) begin
            req_ready[owner] = !fifo_full;
            fifo_write       = accept;
            if (accept)
                fifo_wdata = req_data[int'(owner)*DATA_W +: DATA_W];
        end
        busy     = !rst && (state == HOLD);
        grant_id = rst ? '0 : owner;
    end
endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// tb/tb_sfifo_wr_arbiter.sv - directed and scoreboard bench for sfifo_wr_arbiter
module tb_sfifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_write;
    logic [7:0]  fifo_wdata;
    logic [1:0]  grant_id;
    logic        busy;
    int          n_checks = 0;
    int          n_pass = 0;

    sfifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write(fifo_write),
        .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; req_data = 32'hDDCCBBAA;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (req_ready !== 4'b0) $display("FAIL rst_ready got=%b exp=0000", req_ready); else n_pass++;
        n_checks++; if (fifo_write !== 1'b0) $display("FAIL rst_write got=%b exp=0", fifo_write); else n_pass++;
        n_checks++; if (fifo_wdata !== 8'h00) $display("FAIL rst_wdata got=%h exp=00", fifo_wdata); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_grant got=%0d exp=0", grant_id); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0010; set_data(1, 8'h11);
        #1;
        n_checks++; if (busy !== 1'b0 || fifo_write !== 1'b0 || req_ready !== 4'b0)
            $display("FAIL t1_idle got busy=%b wr=%b rdy=%b exp 0/0/0000", busy, fifo_write, req_ready); else n_pass++;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1; set_data(1, 8'h11 + 8'(b)); #1;
            n_checks++; if (grant_id !== 2'd1) $display("FAIL t1_grant got=%0d exp=1", grant_id); else n_pass++;
            n_checks++; if (fifo_write !== 1'b1) $display("FAIL t1_write got=%b exp=1", fifo_write); else n_pass++;
            n_checks++; if (fifo_wdata !== 8'h11 + 8'(b)) $display("FAIL t1_wdata got=%h exp=%h", fifo_wdata, 8'h11 + 8'(b)); else n_pass++;
            n_checks++; if (req_ready !== 4'b0010) $display("FAIL t1_ready got=%b exp=0010", req_ready); else n_pass++;
        end
        @(posedge clk); #1; req_valid = '0; #1;
        n_checks++; if (fifo_write !== 1'b0 || fifo_wdata !== 8'h00) $display("FAIL t1_drop got wr=%b wd=%h exp 0/00", fifo_write, fifo_wdata); else n_pass++;
        @(posedge clk); #1; req_valid = 4'b1111; #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL t1_idle_after got=%b exp=0", busy); else n_pass++;
        @(posedge clk); #2;
        n_checks++; if (grant_id !== 2'd2) $display("FAIL t1_rrptr got=%0d exp=2", grant_id); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));
        #1;
        for (int g = 0; g < 5; g++) begin
            n_checks++; if (busy !== 1'b0 || fifo_write !== 1'b0) $display("FAIL t2_gap%0d got busy=%b wr=%b exp 0/0", g, busy, fifo_write); else n_pass++;
            for (int b = 0; b < 4; b++) begin
                @(posedge clk); #2;
                n_checks++; if (grant_id !== 2'(g % 4)) $display("FAIL t2_grant got=%0d exp=%0d", grant_id, g % 4); else n_pass++;
                n_checks++; if (fifo_write !== 1'b1 || fifo_wdata !== 8'hA0 + 8'(g % 4))
                    $display("FAIL t2_write got wr=%b wd=%h exp 1/%h", fifo_write, fifo_wdata, 8'hA0 + 8'(g % 4)); else n_pass++;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b0100; set_data(2, 8'h31);
        @(posedge clk); #2;
        n_checks++; if (fifo_write !== 1'b1 || fifo_wdata !== 8'h31) $display("FAIL t3_first got wr=%b wd=%h exp 1/31", fifo_write, fifo_wdata); else n_pass++;
        @(posedge clk); #1; fifo_full = 1'b1; set_data(2, 8'h32); #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            n_checks++; if (fifo_write !== 1'b0 || req_ready !== 4'b0) $display("FAIL t3_stall got wr=%b rdy=%b exp 0/0000", fifo_write, req_ready); else n_pass++;
            n_checks++; if (grant_id !== 2'd2 || busy !== 1'b1) $display("FAIL t3_hold got grant=%0d busy=%b exp 2/1", grant_id, busy); else n_pass++;
        end
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1; fifo_full = 1'b0; set_data(2, 8'h32 + 8'(b)); #1;
            n_checks++; if (fifo_write !== 1'b1 || fifo_wdata !== 8'h32 + 8'(b))
                $display("FAIL t3_resume got wr=%b wd=%h exp 1/%h", fifo_write, fifo_wdata, 8'h32 + 8'(b)); else n_pass++;
        end
        @(posedge clk); #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL t3_burst_end got busy=%b exp 0", busy); else n_pass++;
    endtask

    task automatic test_drop_wrap();
        do_reset();
        req_valid = 4'b1000; set_data(3, 8'h41);
        for (int b = 0; b < 2; b++) begin
            @(posedge clk); #1; set_data(3, 8'h41 + 8'(b)); #1;
            n_checks++; if (fifo_write !== 1'b1 || grant_id !== 2'd3) $display("FAIL t4_beat got wr=%b grant=%0d exp 1/3", fifo_write, grant_id); else n_pass++;
        end
        @(posedge clk); #1; req_valid = 4'b0000; #1;
        n_checks++; if (busy !== 1'b1 || fifo_write !== 1'b0) $display("FAIL t4_drop got busy=%b wr=%b exp 1/0", busy, fifo_write); else n_pass++;
        @(posedge clk); #1; req_valid = 4'b1001; #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL t4_idle got busy=%b exp 0", busy); else n_pass++;
        @(posedge clk); #2;
        n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1) $display("FAIL t4_wrap got grant=%0d busy=%b exp 0/1", grant_id, busy); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'b0100;
        @(posedge clk); #2;
        @(posedge clk); #1; req_valid = 4'b0000; #1;
        @(posedge clk); #1; req_valid = 4'b1000; set_data(3, 8'h51); #1;
        @(posedge clk); #2;
        n_checks++; if (fifo_write !== 1'b1 || grant_id !== 2'd3) $display("FAIL t5_beat1 got wr=%b grant=%0d exp 1/3", fifo_write, grant_id); else n_pass++;
        @(posedge clk); #1; rst = 1'b1; set_data(3, 8'h52); #1;
        n_checks++; if (fifo_write !== 1'b0 || fifo_wdata !== 8'h00) $display("FAIL t5_rst_write got wr=%b wd=%h exp 0/00", fifo_write, fifo_wdata); else n_pass++;
        n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0 || grant_id !== 2'd0)
            $display("FAIL t5_rst_outs got busy=%b rdy=%b grant=%0d exp 0/0000/0", busy, req_ready, grant_id); else n_pass++;
        @(posedge clk); #1; rst = 1'b0; req_valid = 4'b1001; #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL t5_idle got busy=%b exp 0", busy); else n_pass++;
        @(posedge clk); #2;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL t5_rrptr got=%0d exp=0", grant_id); else n_pass++;
    endtask

    task automatic test_scoreboard();
        logic [7:0] fq[$];
        logic [7:0] d;
        logic [3:0] vr;
        logic [3:0] hs;
        int sent[4];
        int exp_seq[4];
        int nread;
        do_reset();
        vr = '0; nread = 0;
        for (int i = 0; i < 4; i++) begin sent[i] = 0; exp_seq[i] = 0; end
        for (int cyc = 0; cyc < 4000 && nread < 80; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!vr[i] && sent[i] < 20 && $urandom_range(0, 3) != 0) vr[i] = 1'b1;
                set_data(i, {2'(i), 6'(sent[i])});
            end
            req_valid = vr;
            fifo_full = (fq.size() >= 4);
            #1;
            hs = req_valid & req_ready;
            n_checks++; if (fifo_write !== (|hs)) $display("FAIL t6_hs got wr=%b hs=%b", fifo_write, hs); else n_pass++;
            if (fifo_full) begin
                n_checks++; if (fifo_write !== 1'b0) $display("FAIL t6_full_write got=%b exp=0", fifo_write); else n_pass++;
            end
            if (fifo_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (hs[i]) begin
                        n_checks++; if (fifo_wdata !== {2'(i), 6'(sent[i])})
                            $display("FAIL t6_wdata got=%h exp=%h", fifo_wdata, {2'(i), 6'(sent[i])}); else n_pass++;
                        sent[i]++;
                        vr[i] = 1'b0;
                    end
                end
                fq.push_back(fifo_wdata);
            end
            if (fq.size() > 0 && $urandom_range(0, 1) == 1) begin
                d = fq.pop_front();
                n_checks++; if (int'(d[5:0]) != exp_seq[d[7:6]])
                    $display("FAIL t6_order prod=%0d got seq=%0d exp=%0d", d[7:6], d[5:0], exp_seq[d[7:6]]); else n_pass++;
                exp_seq[d[7:6]]++;
                nread++;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (nread != 80) $display("FAIL t6_count got=%0d exp=80", nread); else n_pass++;
        req_valid = '0; fifo_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_drop_wrap();
        test_reset_mid_burst();
        test_scoreboard();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
